// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply and one-bit-per-cycle shifts.
// Exposes the value the current step produces so the top can capture it on the last step.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               load,
  input  logic               step,
  input  logic               is_mul,
  input  logic               is_sra,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] n,
  output logic [WIDTH-1:0]   res,
  output logic               carry,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier, sh, sh_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               mode_mul, mode_sra, sh_out;

  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    if (mode_sra) begin
      sh_out = sh[0];
      sh_nxt = {sh[WIDTH-1], sh[WIDTH-1:1]};
    end else begin
      sh_out = sh[WIDTH-1];
      sh_nxt = {sh[WIDTH-2:0], 1'b0};
    end
  end

  // Outputs reflect this cycle's step, i.e. the final answer when last=1.
  assign res   = mode_mul ? acc_nxt[WIDTH-1:0] : sh_nxt;
  assign carry = mode_mul ? |acc_nxt[2*WIDTH-1:WIDTH] : sh_out;
  assign last  = (cnt == CNT_W'(1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      sh       <= '0;
      cnt      <= '0;
      mode_mul <= 1'b0;
      mode_sra <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      mcand    <= {{WIDTH{1'b0}}, a};
      mplier   <= b;
      sh       <= a;
      mode_mul <= is_mul;
      mode_sra <= is_sra;
      cnt      <= is_mul ? CNT_W'(WIDTH) : CNT_W'(n);
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      sh     <= sh_nxt;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: START/BUSY/DONE handshake, single-cycle ops computed here,
// MUL and shifts delegated to alu_iter_unit. Result and flags registered.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY
);

  state_t state, state_nxt;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_res, upd_res, it_res;
  logic [WIDTH:0]     sum;
  logic               sc_carry, upd_carry, upd, it_load, it_step, it_carry, it_last;
  logic               is_shift, iter_op;

  assign shamt    = DATA2[SHAMT_W-1:0];
  assign sum      = {1'b0, DATA1} + {1'b0, DATA2};
  assign is_shift = (SELECT == OP_SLL) || (SELECT == OP_SRA);
  // A zero-length shift completes immediately like the single-cycle ops.
  assign iter_op  = (SELECT == OP_MUL) || (is_shift && (shamt != '0));

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    case (SELECT)
      OP_FWD: sc_res = DATA2;
      OP_ADD: {sc_carry, sc_res} = sum;
      OP_AND: sc_res = DATA1 & DATA2;
      OP_OR:  sc_res = DATA1 | DATA2;
      OP_SUB: begin
        sc_res   = DATA1 - DATA2;
        sc_carry = (DATA1 < DATA2);
      end
      OP_SLL, OP_SRA: sc_res = DATA1;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    it_load   = 1'b0;
    it_step   = 1'b0;
    upd       = 1'b0;
    upd_res   = sc_res;
    upd_carry = sc_carry;
    case (state)
      S_IDLE, S_FIN: begin
        state_nxt = S_IDLE;
        if (START) begin
          if (iter_op) begin
            it_load   = 1'b1;
            state_nxt = S_RUN;
          end else begin
            upd       = 1'b1;
            state_nxt = S_FIN;
          end
        end
      end
      S_RUN: begin
        it_step = 1'b1;
        if (it_last) begin
          upd       = 1'b1;
          upd_res   = it_res;
          upd_carry = it_carry;
          state_nxt = S_FIN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      RESULT <= '0;
      ZERO   <= 1'b0;
      CARRY  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (upd) begin
        RESULT <= upd_res;
        ZERO   <= (upd_res == '0);
        CARRY  <= upd_carry;
      end
    end
  end

  assign BUSY = (state == S_RUN);
  assign DONE = (state == S_FIN);

  alu_iter_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
    .CLK    (CLK),
    .RESET  (RESET),
    .load   (it_load),
    .step   (it_step),
    .is_mul (SELECT == OP_MUL),
    .is_sra (SELECT == OP_SRA),
    .a      (DATA1),
    .b      (DATA2),
    .n      (shamt),
    .res    (it_res),
    .carry  (it_carry),
    .last   (it_last)
  );

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=8): directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_multicycle;

  logic       CLK = 1'b0;
  logic       RESET, START;
  logic [7:0] DATA1, DATA2;
  logic [2:0] SELECT;
  logic       BUSY, DONE, ZERO, CARRY;
  logic [7:0] RESULT;

  int passed = 0;
  int total  = 0;

  alu_multicycle #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
    .SELECT(SELECT), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO), .CARRY(CARRY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {carry, result} from plain integer arithmetic.
  function automatic logic [8:0] model(input int a, input int b, input int sel);
    int r, n, sa;
    bit c;
    n = b % 8;
    c = 1'b0;
    case (sel)
      0: r = b;
      1: begin r = a + b; c = (r > 255); end
      2: r = a & b;
      3: r = a | b;
      4: begin r = a - b; c = (a < b); end
      5: begin r = a * b; c = (r > 255); end
      6: begin r = a << n; c = (n != 0) ? ((a >> (8 - n)) & 1) : 0; end
      default: begin
        sa = (a >= 128) ? a - 256 : a;
        r  = sa >>> n;
        c  = (n != 0) ? ((a >> (n - 1)) & 1) : 0;
      end
    endcase
    return {c, 8'(r & 255)};
  endfunction

  function automatic int lat(input int b, input int sel);
    if (sel < 5) return 1;
    if (sel == 5) return 9;
    return (b % 8 == 0) ? 1 : (b % 8) + 1;
  endfunction

  // Issue one op, scramble inputs after acceptance, then check timing and outputs.
  task automatic run_op(input int a, input int b, input int sel, input string tag);
    logic [8:0] e;
    int el, cyc;
    logic [7:0] prev;
    e    = model(a, b, sel);
    el   = lat(b, sel);
    prev = RESULT;
    DATA1 = 8'(a); DATA2 = 8'(b); SELECT = 3'(sel); START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    DATA1 = 8'($urandom); DATA2 = 8'($urandom); SELECT = 3'($urandom);
    cyc = 1;
    if (el > 1) chk({tag, " busy"}, BUSY, 1);
    while (!DONE && cyc < 40) begin
      chk({tag, " hold"}, RESULT, prev);
      @(posedge CLK); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, el);
    chk({tag, " result"}, RESULT, e[7:0]);
    chk({tag, " carry"}, CARRY, e[8]);
    chk({tag, " zero"}, ZERO, (e[7:0] == 8'd0));
    chk({tag, " busy_fin"}, BUSY, 0);
    @(posedge CLK); #1;
    chk({tag, " done_pulse"}, DONE, 0);
  endtask

  initial begin
    int cyc;
    RESET = 1'b1; START = 1'b0; DATA1 = '0; DATA2 = '0; SELECT = '0;
    #12;
    chk("rst result", RESULT, 0);
    chk("rst zero", ZERO, 0);
    chk("rst carry", CARRY, 0);
    chk("rst busy", BUSY, 0);
    chk("rst done", DONE, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Reset in the middle of a multiply.
    run_op(1, 2, 1, "pre add");
    DATA1 = 8'd7; DATA2 = 8'd9; SELECT = 3'd5; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("midmul busy", BUSY, 1);
    RESET = 1'b1;
    #1;
    chk("midmul rst result", RESULT, 0);
    chk("midmul rst busy", BUSY, 0);
    chk("midmul rst done", DONE, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("midmul no done", DONE, 0);
      @(posedge CLK); #1;
    end
    chk("midmul result kept", RESULT, 0);

    run_op(200, 100, 1, "add 200+100");
    run_op(5, 5, 4, "sub 5-5");
    run_op(3, 5, 4, "sub 3-5");
    run_op(8'h08, 8'h68, 2, "and");
    run_op(8'h0F, 8'hA0, 3, "or");
    run_op(8'h11, 8'h5A, 0, "fwd");
    run_op(12, 13, 5, "mul 12*13");
    run_op(16, 16, 5, "mul 16*16");
    run_op(255, 255, 5, "mul 255*255");
    run_op(8'h81, 1, 6, "sll 1");
    run_op(8'h80, 7, 7, "sra 7");
    run_op(8'h5C, 8, 6, "sll 0");
    run_op(8'h9C, 0, 7, "sra 0");
    run_op(8'h4D, 3, 7, "sra pos 3");

    // START pulsed while busy must be ignored.
    DATA1 = 8'd12; DATA2 = 8'd13; SELECT = 3'd5; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    cyc = 1;
    repeat (2) begin @(posedge CLK); #1; cyc++; end
    DATA1 = 8'd1; DATA2 = 8'd1; SELECT = 3'd1; START = 1'b1;
    @(posedge CLK); #1;
    cyc++;
    START = 1'b0;
    while (!DONE && cyc < 40) begin @(posedge CLK); #1; cyc++; end
    chk("ignore latency", cyc, 9);
    chk("ignore result", RESULT, 156);
    @(posedge CLK); #1;
    chk("ignore no 2nd done", DONE, 0);

    // Back-to-back: new START accepted in the FIN cycle.
    DATA1 = 8'd3; DATA2 = 8'd5; SELECT = 3'd5; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    cyc = 1;
    while (!DONE && cyc < 40) begin @(posedge CLK); #1; cyc++; end
    chk("b2b first result", RESULT, 15);
    DATA1 = 8'd10; DATA2 = 8'd20; SELECT = 3'd1; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("b2b second done", DONE, 1);
    chk("b2b second result", RESULT, 30);
    chk("b2b second carry", CARRY, 0);
    @(posedge CLK); #1;

    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 7)), "random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
